// File: rtl/pc_table_pkg.sv
// Shared types and constants for the run-time programmable branch-target table.
package pc_table_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // Field values written into every entry by the clear sweep.
    localparam logic CLR_VALID = 1'b0;
    localparam logic CLR_REL   = 1'b0;
    localparam int   CLR_DATA  = 0;

endpackage

// File: rtl/pc_target_table.sv
// Branch-target table for fetch: flop storage, clear-sweep FSM and a
// zero-latency read path that resolves PC-relative entries.
module pc_target_table
    import pc_table_pkg::*;
#(
    parameter int D = 10,
    parameter int A = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [D-1:0] pc_in,
    input  logic [A-1:0] rd_addr,
    output logic [D-1:0] target,
    output logic         rd_valid,
    output logic         rd_rel,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [D-1:0] wr_data,
    input  logic         wr_rel,
    input  logic         flush,
    output logic         busy
);

    localparam int DEPTH = 2 ** A;

    typedef struct packed {
        logic         valid;
        logic         rel;
        logic [D-1:0] data;
    } entry_t;

    localparam entry_t CLR_ENTRY = '{
        valid: CLR_VALID,
        rel:   CLR_REL,
        data:  D'(CLR_DATA)
    };

    state_t       state_q;
    state_t       state_d;
    logic [A-1:0] idx_q;
    logic [A-1:0] idx_d;
    logic         clr;
    logic         wr_ok;
    entry_t       mem [DEPTH];
    entry_t       rd_entry;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clr     = 1'b0;
        wr_ok   = 1'b0;
        unique case (state_q)
            INIT: begin
                clr   = ~reset;
                idx_d = idx_q + 1'b1;
                if (idx_q == A'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                // flush takes priority over a same-cycle write
                if (flush) begin
                    state_d = INIT;
                    idx_d   = '0;
                end else begin
                    wr_ok = wr_en & ~reset;
                end
            end
            default: begin
                state_d = INIT;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            mem[idx_q] <= CLR_ENTRY;
        end else if (wr_ok) begin
            mem[wr_addr] <= '{valid: 1'b1, rel: wr_rel, data: wr_data};
        end
    end

    assign busy = reset | (state_q == INIT);

    // Carry-out of the relative add is dropped: targets wrap modulo 2**D.
    always_comb begin
        rd_entry = mem[rd_addr];
        rd_valid = rd_entry.valid;
        rd_rel   = rd_entry.rel;
        if (rd_entry.valid && rd_entry.rel) begin
            target = pc_in + rd_entry.data;
        end else begin
            target = rd_entry.data;
        end
    end

endmodule

// File: tb/tb_pc_target_table.sv
// Directed bench for pc_target_table: vector table for reads/writes plus
// hand-written reset, flush and mid-sweep sequences.
module tb_pc_target_table;

    localparam int D     = 10;
    localparam int A     = 4;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [D-1:0] pc_in = '0;
    logic [A-1:0] rd_addr = '0;
    logic [D-1:0] target;
    logic         rd_valid;
    logic         rd_rel;
    logic         wr_en = 1'b0;
    logic [A-1:0] wr_addr = '0;
    logic [D-1:0] wr_data = '0;
    logic         wr_rel = 1'b0;
    logic         flush = 1'b0;
    logic         busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [A-1:0] ra;
        logic [D-1:0] pc;
        logic         we;
        logic [A-1:0] wa;
        logic [D-1:0] wd;
        logic         wr;
        logic [D-1:0] et;
        logic         ev;
        logic         er;
    } vec_t;

    vec_t vecs [11];

    pc_target_table #(.D(D), .A(A)) dut (
        .clk      (clk),
        .reset    (reset),
        .pc_in    (pc_in),
        .rd_addr  (rd_addr),
        .target   (target),
        .rd_valid (rd_valid),
        .rd_rel   (rd_rel),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_rel   (wr_rel),
        .flush    (flush),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_len(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            step();
        end
        chk(name, n, DEPTH);
    endtask

    task automatic check_all_clear(input string name);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = A'(a);
            #1;
            chk($sformatf("%s[%0d]", name, a),
                {20'b0, rd_valid, rd_rel, target}, 0);
        end
    endtask

    initial begin
        //          ra  pc    we  wa  wd    wr  et    ev  er
        vecs[0]  = '{4'd3, 10'd0,    1'b1, 4'd3, 10'd105,  1'b0, 10'd0,    1'b0, 1'b0};
        vecs[1]  = '{4'd3, 10'd0,    1'b1, 4'd5, 10'd1023, 1'b1, 10'd105,  1'b1, 1'b0};
        vecs[2]  = '{4'd5, 10'd4,    1'b1, 4'd9, 10'd20,   1'b1, 10'd3,    1'b1, 1'b1};
        vecs[3]  = '{4'd5, 10'd0,    1'b0, 4'd0, 10'd0,    1'b0, 10'd1023, 1'b1, 1'b1};
        vecs[4]  = '{4'd9, 10'd1020, 1'b0, 4'd0, 10'd0,    1'b0, 10'd16,   1'b1, 1'b1};
        vecs[5]  = '{4'd9, 10'd100,  1'b1, 4'd9, 10'd50,   1'b0, 10'd120,  1'b1, 1'b1};
        vecs[6]  = '{4'd9, 10'd100,  1'b1, 4'd1, 10'd11,   1'b0, 10'd50,   1'b1, 1'b0};
        vecs[7]  = '{4'd1, 10'd0,    1'b1, 4'd2, 10'd22,   1'b0, 10'd11,   1'b1, 1'b0};
        vecs[8]  = '{4'd2, 10'd0,    1'b1, 4'd7, 10'd1000, 1'b1, 10'd22,   1'b1, 1'b0};
        vecs[9]  = '{4'd7, 10'd30,   1'b0, 4'd0, 10'd0,    1'b0, 10'd6,    1'b1, 1'b1};
        vecs[10] = '{4'd3, 10'd0,    1'b0, 4'd0, 10'd0,    1'b0, 10'd105,  1'b1, 1'b0};

        repeat (3) step();
        chk("busy_in_reset", busy, 1);
        reset = 1'b0;
        sweep_len("reset_sweep_len");
        check_all_clear("reset_clear");
        chk("busy_ready", busy, 0);

        for (int i = 0; i < 11; i++) begin
            rd_addr = vecs[i].ra;
            pc_in   = vecs[i].pc;
            wr_en   = vecs[i].we;
            wr_addr = vecs[i].wa;
            wr_data = vecs[i].wd;
            wr_rel  = vecs[i].wr;
            #1;
            chk($sformatf("vec%0d_target", i), target, vecs[i].et);
            chk($sformatf("vec%0d_valid", i), rd_valid, vecs[i].ev);
            chk($sformatf("vec%0d_rel", i), rd_rel, vecs[i].er);
            step();
        end
        wr_en = 1'b0;
        pc_in = '0;

        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 4'd4;
        wr_data = 10'd77;
        wr_rel  = 1'b0;
        #1;
        chk("busy_pre_flush", busy, 0);
        step();
        flush = 1'b0;
        wr_en = 1'b0;
        sweep_len("flush_sweep_len");
        check_all_clear("flush_clear");

        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (6) step();
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 10'd300;
        step();
        wr_en   = 1'b0;
        rd_addr = 4'd0;
        #1;
        chk("init_write_ignored", rd_valid, 0);
        chk("busy_mid_sweep", busy, 1);
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("busy_mid_reset", busy, 1);
        reset = 1'b0;
        sweep_len("mid_reset_sweep_len");
        check_all_clear("mid_reset_clear");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_target_table.md
Name: pc_target_table

Overview:
Run-time programmable branch-target table for the fetch stage. It replaces the fixed, initial-block target LUT.
- Holds 2**A entries of D-bit targets, each with a valid bit and an absolute/relative mode bit.
- Relative entries resolve to (pc_in + offset) mod 2**D.
- Entries are loaded through a write port. An internal sweep FSM clears the table after reset or flush.

Parameters:
D, 10, target/PC width in bits
A, 4, index width; DEPTH = 2**A entries

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
pc_in  input  D  current PC, used for relative entries
rd_addr  input  A  lookup index from decoded branch instruction
target  output  D  resolved branch target
rd_valid  output  1  entry at rd_addr has been written since last clear
rd_rel  output  1  mode bit of entry at rd_addr (1 = PC-relative)
wr_en  input  1  write request
wr_addr  input  A  write index
wr_data  input  D  absolute target, or two's-complement offset if wr_rel=1
wr_rel  input  1  mode for written entry
flush  input  1  request full table clear
busy  output  1  clear sweep in progress; writes are ignored

Behaviour:
- Storage: per entry {valid, rel, data[D-1:0]}, flops (no RAM inference required).
- States: INIT and READY.
  - reset=1: state<=INIT, idx<=0, busy=1 during reset.
  - Outputs combinational from storage, so target/rd_valid/rd_rel are undefined-safe values only after the sweep: check after busy falls.
- INIT:
  - Each cycle clears entry idx to {0,0,0} and increments idx.
  - When clearing idx==DEPTH-1, next state is READY and idx wraps to 0.
  - busy=1 for exactly DEPTH cycles after reset deasserts.
  - wr_en and flush are ignored in INIT.
- READY:
  - busy=0.
  - wr_en=1 writes {1, wr_rel, wr_data} to wr_addr at the clock edge. Visible on reads the following cycle.
  - No read bypass: a same-cycle read of wr_addr returns the old contents.
  - Back-to-back writes are accepted every cycle. A later write to the same index overwrites.
- flush in READY: next state INIT, idx<=0, sweep restarts. Same-cycle wr_en is dropped; flush wins.
- reset mid-sweep: sweep restarts at idx 0 and takes a full DEPTH cycles.
- Read path (combinational, zero latency):
  - rel=0: target = data.
  - rel=1: target = (pc_in + data) truncated to D bits. data is treated as two's complement, so wrap-around is modulo 2**D.
  - Invalid entry: target = data (0 after clear), rd_valid=0. Fetch must not take the branch when rd_valid=0.
- Widths: the adder is D bits wide and the carry-out is discarded. No sign extension beyond D is needed.

Decomposition:
- Package pc_table_pkg: state enum typedef (INIT, READY) and the cleared-entry constant fields (valid=0, rel=0, data=0).
- Entry width depends on D, so the entry struct is declared inside the module.
- No sub-module. The relative adder is one expression; storage and FSM stay in one file of about 150 lines.

Test Plan:
- Reset: hold reset 3 cycles, release -> busy=1 for exactly 16 cycles then 0; every rd_addr 0..15 gives rd_valid=0, target=0.
- Absolute write: wr addr=3, data=105, rel=0 -> same cycle rd_addr=3 gives rd_valid=0; next cycle target=105, rd_valid=1, rd_rel=0.
- Relative wrap: wr addr=5, data=1023 (-1), rel=1 -> pc_in=4 gives target=3; with pc_in=0, target=1023.
- Relative forward wrap: wr addr=9, data=20, rel=1 -> pc_in=1020 gives target=16; pc_in=100 gives target=120.
- Flush: load entries 1, 2, 7, then assert flush together with wr_en to addr 4 -> busy=1 for 16 cycles, all entries invalid afterwards, addr 4 not written.
- Mid-sweep events: during INIT at idx=6, assert wr_en to addr 0 -> ignored. Then assert reset for 1 cycle at idx=10 -> busy stays 1 for a further 16 cycles after release.
